// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with majority vote, parity/stop checks and valid/ready output
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 19200,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] rx_data_out,
  output logic                  rx_valid,
  output logic                  rx_busy,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun
);
  localparam int RAW_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TICK_DIV = RAW_DIV < 1 ? 1 : RAW_DIV;
  localparam int DIVW = $clog2(TICK_DIV + 1);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [DIVW-1:0] DIV_ONE = (TICK_DIV == 1) ? '0 : DIVW'(1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;
  state_t state, state_n;
  logic s1, s2, prev, fall;
  logic [DIVW-1:0] div_cnt;
  logic [OSW-1:0] os_cnt;
  logic [BW-1:0] bit_cnt;
  logic smp_a, smp_b, par_ok;
  logic [DATA_WIDTH-1:0] shreg;
  logic tick, start, vote_now, vote, done, good, load;
  assign tick = div_cnt == '0;
  assign start = state == IDLE && fall;
  assign vote_now = state != IDLE && tick && os_cnt == OSW'(OVERSAMPLE / 2 + 1);
  assign vote = (smp_a & smp_b) | (smp_a & s2) | (smp_b & s2);
  assign done = state == STOP && vote_now;
  assign good = done && vote && par_ok;
  assign load = good && (!rx_valid || rx_ready);
  assign rx_busy = state != IDLE;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:       state_n = fall ? START : IDLE;
      START:      state_n = vote_now ? (vote ? IDLE : DATA) : START;
      DATA:       state_n = (vote_now && bit_cnt == BW'(DATA_WIDTH - 1)) ? (PARITY != 0 ? PARITY_BIT : STOP) : DATA;
      PARITY_BIT: state_n = vote_now ? STOP : PARITY_BIT;
      STOP:       state_n = vote_now ? IDLE : STOP;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s1 <= 1'b1;
      s2 <= 1'b1;
      prev <= 1'b1;
      fall <= 1'b0;
      div_cnt <= '0;
      os_cnt <= '0;
      bit_cnt <= '0;
      smp_a <= 1'b0;
      smp_b <= 1'b0;
      shreg <= '0;
      par_ok <= 1'b1;
      rx_data_out <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      s1 <= rx;
      s2 <= s1;
      prev <= s2;
      fall <= prev & ~s2;
      // detection cycle is tick 0 of the start bit, so the next tick is offset 1
      div_cnt <= start ? DIV_ONE : (div_cnt == DIVW'(TICK_DIV - 1) ? '0 : div_cnt + 1'b1);
      if (start) os_cnt <= OSW'(1);
      else if (tick) os_cnt <= os_cnt == OSW'(OVERSAMPLE - 1) ? '0 : os_cnt + 1'b1;
      if (tick && os_cnt == OSW'(OVERSAMPLE / 2 - 1)) smp_a <= s2;
      if (tick && os_cnt == OSW'(OVERSAMPLE / 2)) smp_b <= s2;
      if (start) begin
        bit_cnt <= '0;
        par_ok <= 1'b1;
      end
      if (vote_now && state == DATA) begin
        shreg <= {vote, shreg[DATA_WIDTH-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (vote_now && state == PARITY_BIT) par_ok <= vote == (PARITY == 1 ? ~^shreg : ^shreg);
      frame_err <= done & ~vote;
      parity_err <= done & vote & ~par_ok;
      overrun <= good & rx_valid & ~rx_ready;
      rx_valid <= load | (rx_valid & ~rx_ready);
      if (load) rx_data_out <= shreg;
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scenario tasks checking an 8N1 receiver and an 8E1 receiver against a frame-level model
module tb_uart_rx_core;
  logic clk = 1'b0, rst = 1'b1;
  logic rx[2], ready[2], valid_o[2], busy_o[2], fe_o[2], pe_o[2], ov_o[2];
  logic [7:0] data_o[2];
  int cyc = 0, checks = 0, errors = 0, wide = 0;
  int fe_n[2], pe_n[2], ov_n[2], v_n[2], vrise[2], brise[2], bfall[2], fe_t[2], pe_t[2], ov_t[2];
  logic [7:0] vdata[2];
  bit pv[2], pb[2], pfe[2], ppe[2], pov[2];

  uart_rx_core #(.DATA_WIDTH(8), .CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16), .PARITY(0)) dut (
    .clk(clk), .rst(rst), .rx(rx[0]), .rx_ready(ready[0]), .rx_data_out(data_o[0]), .rx_valid(valid_o[0]),
    .rx_busy(busy_o[0]), .frame_err(fe_o[0]), .parity_err(pe_o[0]), .overrun(ov_o[0]));
  uart_rx_core #(.DATA_WIDTH(8), .CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16), .PARITY(2)) dut_p (
    .clk(clk), .rst(rst), .rx(rx[1]), .rx_ready(ready[1]), .rx_data_out(data_o[1]), .rx_valid(valid_o[1]),
    .rx_busy(busy_o[1]), .frame_err(fe_o[1]), .parity_err(pe_o[1]), .overrun(ov_o[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // event recorder: rise times, captured data and pulse counts per receiver
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (valid_o[i] && !pv[i]) begin v_n[i]++; vrise[i] = cyc; vdata[i] = data_o[i]; end
      if (busy_o[i] && !pb[i]) brise[i] = cyc;
      if (!busy_o[i] && pb[i]) bfall[i] = cyc;
      if (fe_o[i]) begin fe_n[i]++; fe_t[i] = cyc; end
      if (pe_o[i]) begin pe_n[i]++; pe_t[i] = cyc; end
      if (ov_o[i]) begin ov_n[i]++; ov_t[i] = cyc; end
      if ((fe_o[i] && pfe[i]) || (pe_o[i] && ppe[i]) || (ov_o[i] && pov[i])) wide++;
      pv[i] = valid_o[i]; pb[i] = busy_o[i]; pfe[i] = fe_o[i]; ppe[i] = pe_o[i]; pov[i] = ov_o[i];
    end
  end

  task automatic hold(input int p, input logic lvl);
    @(posedge clk); #1 rx[p] = lvl;
    repeat (15) @(posedge clk);
  endtask

  task automatic send(input int p, input logic [7:0] d, input bit use_par, input bit pbit, input bit stop, output int t0);
    @(posedge clk); #1 rx[p] = 1'b0; t0 = cyc;
    repeat (15) @(posedge clk);
    for (int b = 0; b < 8; b++) hold(p, d[b]);
    if (use_par) hold(p, pbit);
    hold(p, stop);
  endtask

  task automatic accept(input int p);
    #1 ready[p] = 1'b1;
    @(posedge clk); #1 ready[p] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rx[0] = 1'b1; rx[1] = 1'b1; ready[0] = 1'b0; ready[1] = 1'b0;
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({valid_o[i], busy_o[i], fe_o[i], pe_o[i], ov_o[i]} !== 5'b0) begin errors++; $display("FAIL reset_flags[%0d] got %b exp 00000", i, {valid_o[i], busy_o[i], fe_o[i], pe_o[i], ov_o[i]}); end
      checks++; if (data_o[i] !== 8'h00) begin errors++; $display("FAIL reset_data[%0d] got %h exp 00", i, data_o[i]); end
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_basic;
    int t0, n;
    n = v_n[0];
    send(0, 8'hA5, 0, 0, 1, t0);
    checks++; if (vrise[0] !== t0 + 157) begin errors++; $display("FAIL basic_valid_time got %0d exp %0d", vrise[0], t0 + 157); end
    checks++; if (vdata[0] !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", vdata[0]); end
    checks++; if (brise[0] !== t0 + 4 || bfall[0] !== t0 + 157) begin errors++; $display("FAIL basic_busy got %0d..%0d exp %0d..%0d", brise[0], bfall[0], t0 + 4, t0 + 157); end
    checks++; if (v_n[0] !== n + 1) begin errors++; $display("FAIL basic_count got %0d exp %0d", v_n[0], n + 1); end
    repeat (20) @(posedge clk); #1;
    checks++; if (valid_o[0] !== 1'b1 || data_o[0] !== 8'hA5) begin errors++; $display("FAIL basic_hold got %b/%h exp 1/a5", valid_o[0], data_o[0]); end
    accept(0);
    checks++; if (valid_o[0] !== 1'b0) begin errors++; $display("FAIL basic_accept got %b exp 0", valid_o[0]); end
  endtask

  task automatic test_overrun;
    int t0, o;
    send(0, 8'hA5, 0, 0, 1, t0);
    o = ov_n[0];
    send(0, 8'h3C, 0, 0, 1, t0);
    checks++; if (ov_n[0] !== o + 1 || ov_t[0] !== t0 + 157) begin errors++; $display("FAIL overrun_pulse got n=%0d t=%0d exp n=%0d t=%0d", ov_n[0], ov_t[0], o + 1, t0 + 157); end
    #1;
    checks++; if (valid_o[0] !== 1'b1 || data_o[0] !== 8'hA5) begin errors++; $display("FAIL overrun_keep got %b/%h exp 1/a5", valid_o[0], data_o[0]); end
    accept(0);
    send(0, 8'h81, 0, 0, 1, t0);
    checks++; if (vdata[0] !== 8'h81 || vrise[0] !== t0 + 157) begin errors++; $display("FAIL overrun_next got %h@%0d exp 81@%0d", vdata[0], vrise[0], t0 + 157); end
    accept(0);
  endtask

  task automatic test_glitch;
    int t0, n, f;
    n = v_n[0]; f = fe_n[0] + pe_n[0] + ov_n[0];
    @(posedge clk); #1 rx[0] = 1'b0; t0 = cyc;
    repeat (4) @(posedge clk); #1 rx[0] = 1'b1;
    repeat (40) @(posedge clk); #1;
    checks++; if (brise[0] !== t0 + 4 || bfall[0] !== t0 + 13) begin errors++; $display("FAIL glitch_busy got %0d..%0d exp %0d..%0d", brise[0], bfall[0], t0 + 4, t0 + 13); end
    checks++; if (v_n[0] !== n || fe_n[0] + pe_n[0] + ov_n[0] !== f || busy_o[0] !== 1'b0) begin errors++; $display("FAIL glitch_quiet got v=%0d flags=%0d busy=%b exp v=%0d flags=%0d busy=0", v_n[0], fe_n[0] + pe_n[0] + ov_n[0], busy_o[0], n, f); end
  endtask

  task automatic test_frame_err;
    int t0, n, f;
    n = v_n[0]; f = fe_n[0];
    send(0, 8'h55, 0, 0, 0, t0);
    repeat (40 * 16) @(posedge clk); #1;
    checks++; if (fe_n[0] !== f + 1 || fe_t[0] !== t0 + 157) begin errors++; $display("FAIL frame_err_pulse got n=%0d t=%0d exp n=%0d t=%0d", fe_n[0], fe_t[0], f + 1, t0 + 157); end
    checks++; if (v_n[0] !== n || busy_o[0] !== 1'b0) begin errors++; $display("FAIL frame_err_break got v=%0d busy=%b exp v=%0d busy=0", v_n[0], busy_o[0], n); end
    rx[0] = 1'b1;
    repeat (20) @(posedge clk);
    send(0, 8'h12, 0, 0, 1, t0);
    checks++; if (vdata[0] !== 8'h12 || vrise[0] !== t0 + 157) begin errors++; $display("FAIL frame_err_recover got %h@%0d exp 12@%0d", vdata[0], vrise[0], t0 + 157); end
    accept(0);
  endtask

  task automatic test_parity;
    int t0, p, n;
    p = pe_n[1];
    send(1, 8'h07, 1, 1, 1, t0);
    checks++; if (vdata[1] !== 8'h07 || vrise[1] !== t0 + 173 || pe_n[1] !== p) begin errors++; $display("FAIL parity_good got %h@%0d pe=%0d exp 07@%0d pe=%0d", vdata[1], vrise[1], pe_n[1], t0 + 173, p); end
    accept(1);
    n = v_n[1];
    send(1, 8'h07, 1, 0, 1, t0);
    #1;
    checks++; if (pe_n[1] !== p + 1 || pe_t[1] !== t0 + 173) begin errors++; $display("FAIL parity_bad_pulse got n=%0d t=%0d exp n=%0d t=%0d", pe_n[1], pe_t[1], p + 1, t0 + 173); end
    checks++; if (v_n[1] !== n || valid_o[1] !== 1'b0) begin errors++; $display("FAIL parity_bad_drop got v=%0d valid=%b exp v=%0d valid=0", v_n[1], valid_o[1], n); end
  endtask

  task automatic test_reset_mid;
    int t0;
    logic [7:0] d;
    d = 8'hF0;
    send(0, 8'hA5, 0, 0, 1, t0);
    hold(0, 1'b0);
    for (int b = 0; b < 4; b++) hold(0, d[b]);
    @(posedge clk); #1 rx[0] = d[4];
    repeat (5) @(posedge clk); #1;
    checks++; if (busy_o[0] !== 1'b1 || valid_o[0] !== 1'b1) begin errors++; $display("FAIL reset_mid_pre got busy=%b valid=%b exp 1/1", busy_o[0], valid_o[0]); end
    rst = 1'b1; rx[0] = 1'b1;
    @(posedge clk); #1;
    checks++; if ({valid_o[0], busy_o[0], fe_o[0], pe_o[0], ov_o[0]} !== 5'b0 || data_o[0] !== 8'h00) begin errors++; $display("FAIL reset_mid_outputs got %b/%h exp 00000/00", {valid_o[0], busy_o[0], fe_o[0], pe_o[0], ov_o[0]}, data_o[0]); end
    rst = 1'b0;
    repeat (20) @(posedge clk);
    send(0, 8'hF0, 0, 0, 1, t0);
    checks++; if (vdata[0] !== 8'hF0 || vrise[0] !== t0 + 157) begin errors++; $display("FAIL reset_mid_next got %h@%0d exp f0@%0d", vdata[0], vrise[0], t0 + 157); end
    accept(0);
  endtask

  task automatic test_back_to_back;
    int t0, n;
    logic [7:0] d;
    #1 ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom); n = v_n[0];
      send(0, d, 0, 0, 1, t0);
      checks++; if (vdata[0] !== d || vrise[0] !== t0 + 157 || v_n[0] !== n + 1) begin errors++; $display("FAIL b2b[%0d] got %h@%0d exp %h@%0d", k, vdata[0], vrise[0], d, t0 + 157); end
    end
    #1 ready[0] = 1'b0;
  endtask

  task automatic test_random_parity;
    int t0, n, p;
    logic [7:0] d;
    bit ok, pbit;
    for (int k = 0; k < 10; k++) begin
      d = 8'($urandom); ok = 1'($urandom_range(0, 1));
      pbit = ok ? 1'($countones(d) % 2) : ~1'($countones(d) % 2);
      n = v_n[1]; p = pe_n[1];
      send(1, d, 1, pbit, 1, t0);
      if (ok) begin
        checks++; if (vdata[1] !== d || v_n[1] !== n + 1 || pe_n[1] !== p) begin errors++; $display("FAIL rand_par_good[%0d] got %h v=%0d pe=%0d exp %h v=%0d pe=%0d", k, vdata[1], v_n[1], pe_n[1], d, n + 1, p); end
        accept(1);
      end else begin
        checks++; if (v_n[1] !== n || pe_n[1] !== p + 1) begin errors++; $display("FAIL rand_par_bad[%0d] got v=%0d pe=%0d exp v=%0d pe=%0d", k, v_n[1], pe_n[1], n, p + 1); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_overrun;
    test_glitch;
    test_frame_err;
    test_parity;
    test_reset_mid;
    test_back_to_back;
    test_random_parity;
    checks++; if (wide !== 0) begin errors++; $display("FAIL pulse_width got %0d wide pulses exp 0", wide); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Oversampling UART receiver core: the serial-to-parallel end of the team's UART link, consuming the line driven by the transmitter. It synchronises the asynchronous `rx` line, validates the start bit, majority-votes each bit at mid-period, and checks optional parity and the stop bit. It delivers each byte through a valid/ready handshake, with framing, parity and overrun flags. It sits beside the transmitter under the UART top level.

## Interface
- `DATA_WIDTH`, 8, data bits per frame (5..9)
- `CLK_FREQ`, 50000000, clock frequency in Hz
- `BAUD_RATE`, 19200, line rate in bits/s
- `OVERSAMPLE`, 16, ticks per bit (even, ≥8)
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even
- Derived: `TICK_DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE)`, truncated, minimum 1. The defaults give 162.

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  synchronous reset, active-high
- `rx`  in  1  asynchronous serial line, idle high
- `rx_ready`  in  1  consumer accepts `rx_data_out`
- `rx_data_out`  out  DATA_WIDTH  received word, LSB first on the line
- `rx_valid`  out  1  `rx_data_out` holds an unconsumed word
- `rx_busy`  out  1  frame in progress (state ≠ IDLE)
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0
- `parity_err`  out  1  one-cycle pulse: parity mismatch
- `overrun`  out  1  one-cycle pulse: good frame arrived while `rx_valid` was still high

## Operation
- Input path:
  - `rx` passes through a 2-flop synchroniser, reset to 1, producing `rx_s`.
  - Start detection uses the registered previous value of `rx_s`.
- Tick generator:
  - Counter 0..TICK_DIV-1 produces a one-cycle `tick`.
  - Counter is cleared on start detection, so tick 0 coincides with detection cycle E.
- Bit timing:
  - Bit k spans ticks k·OVERSAMPLE .. k·OVERSAMPLE+OVERSAMPLE-1.
  - k = 0 is start, k = 1..DATA_WIDTH is data, then parity if enabled, then stop.
  - Samples are taken at tick offsets OS/2-1, OS/2 and OS/2+1 within the bit.
  - The 2-of-3 majority is resolved at offset OS/2+1.
- FSM states IDLE, START, DATA, PARITY, STOP:
  - IDLE → START on an `rx_s` 1→0 transition.
  - START: vote = 1 → IDLE (false start, no flags). Vote = 0 → DATA.
  - DATA: each vote is shifted in LSB-first. After DATA_WIDTH votes, go to PARITY if PARITY ≠ 0, else STOP.
  - PARITY: the vote is compared against odd/even parity of the data; the result is latched.
  - STOP: at the vote the state returns to IDLE immediately (mid-stop), so back-to-back frames are caught.
- Stop vote = 1 and parity good:
  - If `rx_valid` = 0: load `rx_data_out`, set `rx_valid`.
  - If `rx_valid` = 1: keep the old data, pulse `overrun`.
- Stop vote = 1 with parity bad: pulse `parity_err`. Data is not delivered and `rx_valid` is unchanged.
- Stop vote = 0: pulse `frame_err`. Data is discarded. Return to IDLE.
  - No new start is detected until `rx_s` has been seen high, which covers a break.
- Handshake:
  - `rx_valid` clears the cycle after `rx_valid & rx_ready`.
  - If a new word loads in the same cycle as an accept, the load wins: `rx_valid` stays 1 with the new data and no overrun.
- Reset, mid-frame or otherwise:
  - FSM → IDLE; all counters cleared.
  - Pending flags dropped; synchroniser flops set to 1.

## Timing
- Reset values:
  - `rx_data_out` = 0
  - `rx_valid` = 0
  - `rx_busy` = 0
  - `frame_err`, `parity_err`, `overrun` = 0
- Start detection cycle E = raw `rx` fall + 2 cycles (synchroniser) + 1 (edge register).
- The vote for bit k occurs at cycle E + (k·OS + OS/2 + 1)·TICK_DIV.
- `rx_valid` and each error/overrun pulse assert on the cycle after the stop vote.
- `rx_busy` goes high the cycle after E and low the cycle after the stop vote.
- Example, TICK_DIV = 1, OS = 16, 8N1:
  - Stop vote at E+153.
  - `rx_valid` high at E+154.
- All flag pulses are exactly one cycle wide.

## Test plan
Bench parameters: CLK_FREQ=1600000, BAUD_RATE=100000, OVERSAMPLE=16 (TICK_DIV=1, 16 clk/bit).
- 8N1 frame 0xA5, `rx_ready`=0 → `rx_valid` rises E+154 with `rx_data_out`=0xA5 and holds. Pulse `rx_ready` → `rx_valid`=0 next cycle.
- Second frame 0x3C while 0xA5 is unconsumed → `overrun` pulses one cycle, `rx_data_out` stays 0xA5. After accept, a third frame 0x81 delivers normally.
- 4-clock low glitch on idle `rx` → returns to IDLE after the START vote. No `rx_valid`, no flags.
- Frame 0x55 with stop bit driven 0, then line held low 40 bit-times → one `frame_err` pulse, no `rx_valid`. No new frame until `rx` returns high, then frame 0x12 delivers.
- PARITY=2: frame 0x07 with parity bit 1 → no error, data delivered. Parity bit 0 → `parity_err` pulse, no `rx_valid`.
- `rst` asserted at bit 4 of a frame → all outputs 0 next cycle. A following clean frame 0xF0 is received correctly.
